// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-domain consumer that drains a burst of words from the async FIFO and replays
// them on a valid/ready stream through a 2-entry skid buffer. Optional feature macro: DRAIN_CNT_EN.
module fifo_rd_drain #(
  parameter int data_width = 4,
  parameter int len_width  = 8,
  parameter int rd_lat     = 1   // 1 or 2 only
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [len_width-1:0]  burst_len_in,
  input  logic                  fifo_empty_in,
  input  logic                  fifo_almost_empty_in,
  input  logic [data_width-1:0] fifo_data_in,
  output logic                  fifo_pop_out,
  output logic [data_width-1:0] m_data_out,
  output logic                  m_valid_out,
  input  logic                  m_ready_in,
  output logic                  busy_out,
  output logic                  done_out
`ifdef DRAIN_CNT_EN
  ,
  output logic [15:0]           drain_cnt_out
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [len_width:0] one_word   = (len_width + 1)'(1);
  localparam logic [len_width:0] full_burst = one_word << len_width;

  state_t                state, state_nxt;
  logic [len_width:0]    remaining;
  logic [rd_lat-1:0]     pop_pipe;
  logic [1:0]            inflight;
  logic [data_width-1:0] skid_mem [2];
  logic                  skid_wr_ptr, skid_rd_ptr;
  logic [1:0]            skid_count;
  logic                  arrive, handshake, last_pop;
  logic [2:0]            occupancy;

  always_comb begin
    inflight = 2'd0;
    for (int i = 0; i < rd_lat; i++) inflight = inflight + 2'(pop_pipe[i]);
  end

  assign arrive      = pop_pipe[rd_lat-1];
  assign m_valid_out = (skid_count != 2'd0);
  assign handshake   = m_valid_out && m_ready_in;
  assign m_data_out  = m_valid_out ? skid_mem[skid_rd_ptr] : '0;

  // Every popped word needs a guaranteed skid slot. A slot freed by this cycle's handshake is
  // reusable at once, which is what sustains one word per cycle with rd_lat=1.
  assign occupancy = 3'(inflight) + 3'(skid_count) - 3'(handshake);

  assign fifo_pop_out = (state == DRAIN) && !fifo_empty_in && (remaining != '0) &&
                        (occupancy < 3'd2) && !(fifo_almost_empty_in && (inflight != 2'd0));
  assign last_pop     = fifo_pop_out && (remaining == one_word);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    busy_out  = 1'b0;
    done_out  = 1'b0;
    case (state)
      IDLE:  if (start_in) state_nxt = DRAIN;
      DRAIN: begin
        busy_out = 1'b1;
        if (last_pop) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy_out = 1'b1;
        // Leave as the last word's handshake completes so done follows it by one cycle.
        if ((inflight == 2'd0) &&
            ((skid_count == 2'd0) || ((skid_count == 2'd1) && handshake)))
          state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      remaining   <= '0;
      pop_pipe    <= '0;
      skid_wr_ptr <= 1'b0;
      skid_rd_ptr <= 1'b0;
      skid_count  <= 2'd0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && start_in)
        remaining <= (burst_len_in == '0) ? full_burst : {1'b0, burst_len_in};
      else if (fifo_pop_out)
        remaining <= remaining - one_word;
      pop_pipe <= rd_lat'({pop_pipe, fifo_pop_out});
      if (arrive)    skid_wr_ptr <= ~skid_wr_ptr;
      if (handshake) skid_rd_ptr <= ~skid_rd_ptr;
      skid_count <= skid_count + 2'(arrive) - 2'(handshake);
    end
  end

  // NOTE: skid storage holds data only; validity lives in skid_count, so the array is not reset.
  always_ff @(posedge clk_in) begin
    if (arrive) skid_mem[skid_wr_ptr] <= fifo_data_in;
  end

`ifdef DRAIN_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in)         drain_cnt_out <= 16'd0;
    else if (handshake) drain_cnt_out <= drain_cnt_out + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: directed bench with a queue-based FIFO model and a word-level stream scoreboard.
module tb_fifo_rd_drain;
  localparam int DW = 4;
  localparam int LW = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, start_in, fifo_empty_in, fifo_almost_empty_in, m_ready_in;
  logic [LW-1:0] burst_len_in;
  logic [DW-1:0] fifo_data_in;
  logic          fifo_pop_out, m_valid_out, busy_out, done_out;
  logic [DW-1:0] m_data_out;
`ifdef DRAIN_CNT_EN
  logic [15:0]   drain_cnt_out;
`endif

  always #5 clk_in = ~clk_in;

  fifo_rd_drain #(.data_width(DW), .len_width(LW), .rd_lat(1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .burst_len_in(burst_len_in),
    .fifo_empty_in(fifo_empty_in), .fifo_almost_empty_in(fifo_almost_empty_in),
    .fifo_data_in(fifo_data_in), .fifo_pop_out(fifo_pop_out), .m_data_out(m_data_out),
    .m_valid_out(m_valid_out), .m_ready_in(m_ready_in), .busy_out(busy_out),
    .done_out(done_out)
`ifdef DRAIN_CNT_EN
    , .drain_cnt_out(drain_cnt_out)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // FIFO model contents, words popped but not yet delivered, and per-burst logs.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] log_q[$];
  int            pop_cyc[$];
  bit            force_ae = 1'b0, mon_en = 1'b0, pop_at_edge = 1'b0;
  bit            busy_exp, done_exp, prev_valid, prev_ready, prev_pop;
  logic [DW-1:0] prev_data;
  int cyc = 0, burst_left = 0, burst_len_exp = 0, pops_in_burst = 0, delivered = 0;
  int done_seen = 0, last_hs_cyc = 0, done_cyc = 0, hs_total = 0;

  task automatic update_flags();
    fifo_empty_in        = (fq.size() == 0);
    fifo_almost_empty_in = force_ae || (fq.size() <= 1);
  endtask

  task automatic fill(input int n, input int base);
    for (int i = 0; i < n; i++) fq.push_back(DW'(base + i));
    update_flags();
  endtask

  // One clock: the FIFO model answers a pop seen in the cycle just ended with next-cycle data.
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (pop_at_edge) begin
      if (fq.size() == 0) check("model_fifo_underflow", 1'b0, 0, 1);
      else begin
        fifo_data_in = fq.pop_front();
        exp_q.push_back(fifo_data_in);
      end
    end
    update_flags();
  endtask

  task automatic reset_model();
    exp_q.delete();
    busy_exp = 1'b0; done_exp = 1'b0; prev_valid = 1'b0; prev_ready = 1'b0; prev_pop = 1'b0;
    burst_left = 0; hs_total = 0;
  endtask

  task automatic start_burst(input logic [LW-1:0] len);
    pops_in_burst = 0; delivered = 0;
    log_q.delete(); pop_cyc.delete();
    burst_len_in = len;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int seen0 = done_seen;
    int n = 0;
    while (done_seen == seen0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_done_timeout"}, done_seen != seen0, n, budget);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_pop"},   fifo_pop_out == 1'b0, fifo_pop_out, 0);
    check({name, "_valid"}, m_valid_out == 1'b0,  m_valid_out, 0);
    check({name, "_data"},  m_data_out == '0,     m_data_out, 0);
    check({name, "_busy"},  busy_out == 1'b0,     busy_out, 0);
    check({name, "_done"},  done_out == 1'b0,     done_out, 0);
  endtask

  // Scoreboard: burst-level model of busy/done, word order, backpressure and pop legality.
  always @(negedge clk_in) begin
    bit            hs, busy_nxt, done_nxt;
    logic [DW-1:0] w;
    cyc++;
    pop_at_edge = fifo_pop_out;
    if (mon_en) begin
      hs       = m_valid_out && m_ready_in;
      busy_nxt = busy_exp;
      done_nxt = 1'b0;
      check("busy", busy_out == busy_exp, busy_out, busy_exp);
      check("done", done_out == done_exp, done_out, done_exp);
      check("outstanding", exp_q.size() <= 2, exp_q.size(), 2);
`ifdef DRAIN_CNT_EN
      check("drain_cnt", drain_cnt_out == 16'(hs_total), drain_cnt_out, hs_total);
`endif
      if (done_out) begin
        done_seen++;
        done_cyc = cyc;
      end
      if (fifo_pop_out) begin
        check("pop_not_empty", !fifo_empty_in, fifo_empty_in, 0);
        check("pop_within_burst", pops_in_burst < burst_len_exp, pops_in_burst, burst_len_exp);
        if (fifo_almost_empty_in) check("ae_one_in_flight", !prev_pop, prev_pop, 0);
        pops_in_burst++;
        pop_cyc.push_back(cyc);
      end
      if (prev_valid && !prev_ready) begin
        check("hold_valid", m_valid_out == 1'b1, m_valid_out, 1);
        check("hold_data", m_data_out == prev_data, m_data_out, prev_data);
      end
      if (hs) begin
        if (exp_q.size() == 0) check("hs_without_word", 1'b0, m_data_out, -1);
        else begin
          w = exp_q.pop_front();
          check("data", m_data_out == w, m_data_out, w);
        end
        log_q.push_back(m_data_out);
        delivered++;
        hs_total++;
        last_hs_cyc = cyc;
        if (burst_left == 1) begin
          busy_nxt = 1'b0;
          done_nxt = 1'b1;
        end
        if (burst_left > 0) burst_left--;
      end
      if (start_in && !busy_exp && !done_exp) begin
        busy_nxt      = 1'b1;
        burst_len_exp = (burst_len_in == '0) ? (1 << LW) : int'(burst_len_in);
        burst_left    = burst_len_exp;
      end
      busy_exp   = busy_nxt;
      done_exp   = done_nxt;
      prev_valid = m_valid_out;
      prev_ready = m_ready_in;
      prev_data  = m_data_out;
      prev_pop   = fifo_pop_out;
    end
  end

  initial begin
    int n;
    rst_in = 1'b1; start_in = 1'b0; burst_len_in = '0; m_ready_in = 1'b1; fifo_data_in = '0;
    update_flags();
    reset_model();
    tick(); tick();
    check_outputs_zero("reset");
`ifdef DRAIN_CNT_EN
    check("reset_drain_cnt", drain_cnt_out == 16'd0, drain_cnt_out, 0);
`endif
    rst_in = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: four words from a six-deep FIFO, pops back to back, done one cycle after last handshake.
    fill(6, 1);
    start_burst(4'd4);
    wait_done("t1", 40);
    check("t1_delivered", delivered == 4, delivered, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) check("t1_word", log_q[i] == DW'(i + 1), log_q[i], i + 1);
    end
    check("t1_pop_count", pop_cyc.size() == 4, pop_cyc.size(), 4);
    if (pop_cyc.size() == 4) check("t1_pop_span", pop_cyc[3] - pop_cyc[0] == 3, pop_cyc[3] - pop_cyc[0], 3);
    check("t1_done_lag", done_cyc - last_hs_cyc == 1, done_cyc - last_hs_cyc, 1);
    check("t1_fifo_left", fq.size() == 2, fq.size(), 2);
    fq.delete(); update_flags(); tick();

    // 2: FIFO empty for five cycles after start, then three words appear.
    start_burst(4'd3);
    repeat (5) tick();
    check("t2_no_pop_while_empty", pops_in_burst == 0, pops_in_burst, 0);
    check("t2_busy_waiting", busy_out == 1'b1, busy_out, 1);
    fill(3, 4'hA);
    wait_done("t2", 40);
    check("t2_delivered", delivered == 3, delivered, 3);
    if (log_q.size() == 3) check("t2_last_word", log_q[2] == 4'hC, log_q[2], 12);
    tick();

    // 3: backpressure after the first word; a start during the burst must be ignored.
    fill(10, 8);
    start_burst(4'd8);
    n = 0;
    while (delivered < 1 && n < 20) begin
      tick();
      n++;
    end
    check("t3_first_word_timeout", delivered >= 1, n, 20);
    m_ready_in = 1'b0;
    repeat (5) tick();
    check("t3_pops_stalled", pops_in_burst == 3, pops_in_burst, 3);
    check("t3_head_valid", m_valid_out == 1'b1, m_valid_out, 1);
    check("t3_head_word", m_data_out == 4'd9, m_data_out, 9);
    burst_len_in = 4'd2; start_in = 1'b1; tick(); start_in = 1'b0;
    m_ready_in = 1'b1;
    wait_done("t3", 60);
    check("t3_delivered", delivered == 8, delivered, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < log_q.size()) check("t3_word", log_q[i] == DW'(8 + i), log_q[i], 8 + i);
    end
    check("t3_fifo_left", fq.size() == 2, fq.size(), 2);
    fq.delete(); update_flags(); tick();

    // 4: almost-empty held high: pops spaced rd_lat+1 = 2 cycles apart.
    force_ae = 1'b1;
    fill(6, 3);
    start_burst(4'd4);
    wait_done("t4", 60);
    check("t4_delivered", delivered == 4, delivered, 4);
    check("t4_pop_count", pop_cyc.size() == 4, pop_cyc.size(), 4);
    for (int i = 1; i < 4; i++) begin
      if (i < pop_cyc.size()) check("t4_pop_gap", pop_cyc[i] - pop_cyc[i-1] == 2, pop_cyc[i] - pop_cyc[i-1], 2);
    end
    force_ae = 1'b0;
    fq.delete(); update_flags(); tick();

    // 5: burst length 0 drains 2**len_width = 16 words.
    fill(18, 0);
    start_burst(4'd0);
    wait_done("t5", 120);
    check("t5_delivered", delivered == 16, delivered, 16);
    check("t5_fifo_left", fq.size() == 2, fq.size(), 2);
    if (log_q.size() == 16) check("t5_last_word", log_q[15] == 4'hF, log_q[15], 15);
    fq.delete(); update_flags(); tick();

    // 6: reset after the second word of five, then a one-word burst.
    fill(8, 5);
    start_burst(4'd5);
    n = 0;
    while (delivered < 2 && n < 30) begin
      tick();
      n++;
    end
    check("t6_two_words_timeout", delivered >= 2, n, 30);
    mon_en = 1'b0;
    rst_in = 1'b1;
    tick();
    check_outputs_zero("t6_after_reset");
    rst_in = 1'b0;
    reset_model();
    mon_en = 1'b1;
    tick();
    check("t6_idle_after_reset", busy_out == 1'b0, busy_out, 0);
    n = fq.size();
    start_burst(4'd1);
    wait_done("t6", 30);
    check("t6_delivered", delivered == 1, delivered, 1);
    check("t6_one_pop", fq.size() == n - 1, fq.size(), n - 1);
`ifdef DRAIN_CNT_EN
    check("t6_drain_cnt", drain_cnt_out == 16'd1, drain_cnt_out, 1);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
